// File: rtl/muldiv_iter_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU; stalls the pipeline while busy.
// Optional last-result cache enabled by defining MULDIV_DIV_CACHE_EN.
`timescale 1ns/1ps
module muldiv_iter_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;
  localparam logic [WIDTH-1:0] MinNeg  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CntW-1:0]  LastCnt = CntW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, div_q, div_d, result_q, result_d;
  logic             sel_rem_q, sel_rem_d, quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;
  logic             special_q, special_d;

  logic             is_signed, a_neg, b_neg, div_zero, overflow, special_case, cache_hit;
  logic [WIDTH-1:0] a_mag, b_mag, quo_fix, rem_fix, cache_result;
  logic [WIDTH:0]   rem_sh, trial;

  assign is_signed    = ~op[0];
  assign a_neg        = is_signed & a[WIDTH-1];
  assign b_neg        = is_signed & b[WIDTH-1];
  assign a_mag        = a_neg ? -a : a;
  assign b_mag        = b_neg ? -b : b;
  assign div_zero     = (b == '0);
  assign overflow     = is_signed & (a == MinNeg) & (&b);
  assign special_case = div_zero | overflow;

  assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
  assign trial   = rem_sh - {1'b0, div_q};
  assign quo_fix = quo_neg_q ? -quo_q : quo_q;
  assign rem_fix = rem_neg_q ? -rem_q : rem_q;

`ifdef MULDIV_DIV_CACHE_EN
  logic             cache_valid_q, cache_valid_d, cache_signed_q, cache_signed_d;
  logic             cur_signed_q, cur_signed_d;
  logic [WIDTH-1:0] cache_a_q, cache_a_d, cache_b_q, cache_b_d;
  logic [WIDTH-1:0] cache_quo_q, cache_quo_d, cache_rem_q, cache_rem_d;
  logic [WIDTH-1:0] cur_a_q, cur_a_d, cur_b_q, cur_b_d;

  // DIV/REM and DIVU/REMU share an entry: only raw operands and signedness must match.
  assign cache_hit    = cache_valid_q && (a == cache_a_q) && (b == cache_b_q) &&
                        (is_signed == cache_signed_q);
  assign cache_result = op[1] ? cache_rem_q : cache_quo_q;
`else
  assign cache_hit    = 1'b0;
  assign cache_result = '0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    div_d     = div_q;
    result_d  = result_q;
    sel_rem_d = sel_rem_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    special_d = special_q;
`ifdef MULDIV_DIV_CACHE_EN
    cache_valid_d  = cache_valid_q;
    cache_signed_d = cache_signed_q;
    cache_a_d      = cache_a_q;
    cache_b_d      = cache_b_q;
    cache_quo_d    = cache_quo_q;
    cache_rem_d    = cache_rem_q;
    cur_signed_d   = cur_signed_q;
    cur_a_d        = cur_a_q;
    cur_b_d        = cur_b_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sel_rem_d = op[1];
          cnt_d     = '0;
`ifdef MULDIV_DIV_CACHE_EN
          cur_signed_d = is_signed;
          cur_a_d      = a;
          cur_b_d      = b;
`endif
          if (cache_hit) begin
            state_d  = StDone;
            result_d = cache_result;
          end else if (special_case) begin
            // Final values preloaded so FIX passes them through unchanged.
            state_d   = StFix;
            quo_d     = div_zero ? '1 : MinNeg;
            rem_d     = div_zero ? a : '0;
            quo_neg_d = 1'b0;
            rem_neg_d = 1'b0;
            special_d = 1'b1;
          end else begin
            state_d   = StCalc;
            quo_d     = a_mag;
            rem_d     = '0;
            div_d     = b_mag;
            quo_neg_d = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            special_d = 1'b0;
          end
        end
      end
      StCalc: begin
        rem_d = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) state_d = StFix;
      end
      StFix: begin
        state_d  = StDone;
        result_d = sel_rem_q ? rem_fix : quo_fix;
`ifdef MULDIV_DIV_CACHE_EN
        if (!special_q) begin
          cache_valid_d  = 1'b1;
          cache_signed_d = cur_signed_q;
          cache_a_d      = cur_a_q;
          cache_b_d      = cur_b_q;
          cache_quo_d    = quo_fix;
          cache_rem_d    = rem_fix;
        end
`endif
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (kill) begin
      state_d  = StIdle;
      result_d = result_q;
`ifdef MULDIV_DIV_CACHE_EN
      cache_valid_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      result_q  <= '0;
      sel_rem_q <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      special_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
      result_q  <= result_d;
      sel_rem_q <= sel_rem_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      special_q <= special_d;
    end
  end

`ifdef MULDIV_DIV_CACHE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_valid_q  <= 1'b0;
      cache_signed_q <= 1'b0;
      cache_a_q      <= '0;
      cache_b_q      <= '0;
      cache_quo_q    <= '0;
      cache_rem_q    <= '0;
      cur_signed_q   <= 1'b0;
      cur_a_q        <= '0;
      cur_b_q        <= '0;
    end else begin
      cache_valid_q  <= cache_valid_d;
      cache_signed_q <= cache_signed_d;
      cache_a_q      <= cache_a_d;
      cache_b_q      <= cache_b_d;
      cache_quo_q    <= cache_quo_d;
      cache_rem_q    <= cache_rem_d;
      cur_signed_q   <= cur_signed_d;
      cur_a_q        <= cur_a_d;
      cur_b_q        <= cur_b_d;
    end
  end
`endif

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_iter_div.sv
// Bench for muldiv_iter_div: arithmetic reference model checked every cycle, plus directed
// literal cases. Define MULDIV_DIV_CACHE_EN for both RTL and bench to exercise the cache.
`timescale 1ns/1ps
module tb_muldiv_iter_div;
  localparam int unsigned W = 32;
  localparam logic [1:0] OpDiv = 2'b00, OpDivu = 2'b01, OpRem = 2'b10, OpRemu = 2'b11;
`ifdef MULDIV_DIV_CACHE_EN
  localparam int HitLat = 1;
`else
  localparam int HitLat = W + 2;
`endif

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, kill = 1'b0;
  logic [1:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done;
  logic [W-1:0] result;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  muldiv_iter_div #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .kill(kill),
    .busy(busy), .done(done), .result(result)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_left;  // cycles until (and including) the done cycle; 0 = idle
  logic [31:0] m_result, m_pend, m_pa, m_pb, c_a, c_b;
  logic        m_cacheable, m_psgn, c_valid, c_sgn;

  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, y);
    longint sx, sy, q, r;
    if (y == 0) return o[1] ? x : 32'hFFFF_FFFF;
    if (!o[0]) begin sx = $signed(x); sy = $signed(y); end
    else begin sx = {32'b0, x}; sy = {32'b0, y}; end
    q = sx / sy;
    r = sx % sy;
    return o[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] x, y);
    return (y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] x, y);
    if (is_special(o, x, y)) return 2;
`ifdef MULDIV_DIV_CACHE_EN
    if (c_valid && x == c_a && y == c_b && (!o[0]) == c_sgn) return 1;
`endif
    return W + 2;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0; m_result <= '0; m_pend <= '0; c_valid <= 1'b0;
      m_cacheable <= 1'b0; m_pa <= '0; m_pb <= '0; m_psgn <= 1'b0;
      c_a <= '0; c_b <= '0; c_sgn <= 1'b0;
    end else if (kill) begin
      m_left  <= 0;
      c_valid <= 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        m_left      <= exp_lat(op, a, b);
        m_pend      <= ref_div(op, a, b);
        m_cacheable <= !is_special(op, a, b);
        m_pa <= a; m_pb <= b; m_psgn <= !op[0];
        if (exp_lat(op, a, b) == 1) m_result <= ref_div(op, a, b);
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) begin
        m_result <= m_pend;
        if (m_cacheable) begin
          c_valid <= 1'b1; c_a <= m_pa; c_b <= m_pb; c_sgn <= m_psgn;
        end
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", 32'(busy), 32'(m_left != 0));
      check("done", 32'(done), 32'(m_left == 1));
      check("result", result, m_result);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic launch(input logic [1:0] o, input logic [31:0] x, y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic await_done(input string name, input logic [31:0] exp, input int lat_exp);
    int lat = 0;
    bit seen = 0;
    for (int i = 1; i <= int'(W) + 10; i++) begin
      @(negedge clk);
      if (done) begin lat = i; seen = 1; break; end
    end
    check({name, " done seen"}, 32'(seen), 32'd1);
    check({name, " latency"}, 32'(lat), 32'(lat_exp));
    check({name, " result"}, result, exp);
  endtask

  task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] x, y,
                       input logic [31:0] exp, input int lat_exp);
    @(posedge clk); #1;
    launch(o, x, y);
    await_done(name, exp, lat_exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [31:0] last_a, last_b;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    rst_n = 1'b1;

    do_op("divu 100/7", OpDivu, 32'd100, 32'd7, 32'd14, 34);
    do_op("remu 100/7", OpRemu, 32'd100, 32'd7, 32'd2, HitLat);
    do_op("div -100/7", OpDiv, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34);
    do_op("rem -100/7", OpRem, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, HitLat);
    do_op("div by zero", OpDiv, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 2);
    do_op("rem by zero", OpRem, 32'h1234_5678, 32'd0, 32'h1234_5678, 2);
    do_op("div overflow", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    do_op("rem overflow", OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);

    // Kill in cycle 10 of DIVU 50/5; new request right after the kill edge
    @(posedge clk); #1;
    launch(OpDivu, 32'd50, 32'd5);
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill busy", 32'(busy), 32'd0);
    check("kill done", 32'(done), 32'd0);
    check("kill result kept", result, 32'd0);
    launch(OpDivu, 32'd1000, 32'd3);
    await_done("after kill divu 1000/3", 32'd333, 34);

    do_op("div 1000/-3", OpDiv, 32'd1000, 32'hFFFF_FFFD, 32'hFFFF_FEB3, 34);
    do_op("rem 1000/-3", OpRem, 32'd1000, 32'hFFFF_FFFD, 32'd1, HitLat);
    // Kill while idle invalidates the cache
    @(posedge clk); #1 kill = 1'b1;
    @(posedge clk); #1 kill = 1'b0;
    do_op("rem 1000/-3 after kill", OpRem, 32'd1000, 32'hFFFF_FFFD, 32'd1, 34);
    do_op("div 1000/-3 again", OpDiv, 32'd1000, 32'hFFFF_FFFD, 32'hFFFF_FEB3, HitLat);

    // Asynchronous reset mid-operation
    @(posedge clk); #1;
    launch(OpDiv, 32'd12345, 32'd67);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midop reset busy", 32'(busy), 32'd0);
    check("midop reset done", 32'(done), 32'd0);
    check("midop reset result", result, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Randomized traffic, checked every cycle by the compare process
    last_a = 32'd1; last_b = 32'd1;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      kill  = ($urandom_range(0, 79) == 0);
      op    = 2'($urandom);
      case ($urandom_range(0, 7))
        0: begin a = $urandom; b = '0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2, 3: begin a = last_a; b = last_b; end
        4: begin
          a = $urandom_range(0, 999);
          b = $urandom_range(1, 20);
          if ($urandom_range(0, 1) == 1) a = -a;
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
      endcase
      if (start) begin last_a = a; last_b = b; end
    end
    #0 start = 1'b0;
    kill = 1'b0;
    repeat (W + 5) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
